rbz_spi_seq: RTL

Sequencer that owns one shared SPI shift engine and uses it to drive the raybox-zero renderer's two SPI configuration ports: the vector port (camera position and direction) and the register port (control registers). Two requesters, a vector source and a register source, present whole frames through req/ack handshakes. The block arbitrates between them, serialises the winning frame MSB-first in SPI mode 0 onto the matching bus, and keeps the other bus idle. It sits between on-chip control logic and the renderer's `i_vec_*` / `i_reg_*` inputs.

---
 rtl/rbz_spi_seq.sv | 105 ++++++++++
 1 files changed

// File: rtl/rbz_spi_seq.sv
// rbz_spi_seq: arbitrates vector/register frame requests onto one shared SPI mode-0 shift engine.
// Optional RBZ_SEQ_VBLANK_GATE_EN makes vector requests eligible only during vertical blanking.
`timescale 1ns/1ps
module rbz_spi_seq #(
  parameter int CLK_DIV    = 2,
  parameter int VEC_BITS   = 96,
  parameter int REG_BITS   = 28,
  parameter int GAP_CYCLES = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_vec_req,
  input  logic [VEC_BITS-1:0] i_vec_data,
  output logic                o_vec_ack,
  input  logic                i_reg_req,
  input  logic [REG_BITS-1:0] i_reg_data,
  output logic                o_reg_ack,
  input  logic                i_vblank,
  output logic                o_vec_csb,
  output logic                o_vec_sclk,
  output logic                o_vec_mosi,
  output logic                o_reg_csb,
  output logic                o_reg_sclk,
  output logic                o_reg_mosi,
  output logic                o_busy
);
  localparam int W  = (VEC_BITS > REG_BITS) ? VEC_BITS : REG_BITS;
  localparam int CW = $clog2(W + 1);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
  state_t state, state_n;
  logic sel, last_reg, sclk, vec_ok, grant_reg, any_req, div_end, last_bit, gap_end, act;
  logic [W-1:0] shreg;
  logic [CW-1:0] cnt;
  logic [DW-1:0] div;
  logic [GW-1:0] gcnt;
  always_comb begin
`ifdef RBZ_SEQ_VBLANK_GATE_EN
    vec_ok = i_vec_req & i_vblank;
`else
    vec_ok = i_vec_req & (i_vblank | 1'b1);
`endif
    any_req = vec_ok | i_reg_req;
    // on a tie the register port wins unless it was granted last
    grant_reg = i_reg_req & (!vec_ok | !last_reg);
    div_end = div == DW'(CLK_DIV - 1);
    last_bit = div_end & sclk & (cnt == CW'(1));
    gap_end = gcnt == GW'(GAP_CYCLES - 1);
    state_n = state;
    case (state)
      IDLE:    state_n = any_req ? LOAD : IDLE;
      LOAD:    state_n = SHIFT;
      SHIFT:   state_n = last_bit ? GAP : SHIFT;
      default: state_n = gap_end ? IDLE : GAP;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sel <= 1'b0;
      last_reg <= 1'b0;
      shreg <= '0;
      cnt <= '0;
      div <= '0;
      sclk <= 1'b0;
      gcnt <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          sel <= grant_reg;
          last_reg <= grant_reg;
        end
        LOAD: begin
          shreg <= sel ? W'(i_reg_data) << (W - REG_BITS) : W'(i_vec_data) << (W - VEC_BITS);
          cnt <= sel ? CW'(REG_BITS) : CW'(VEC_BITS);
          div <= '0;
          sclk <= 1'b0;
          gcnt <= '0;
        end
        SHIFT: begin
          div <= div_end ? '0 : div + DW'(1);
          if (div_end) sclk <= !sclk;
          if (div_end & sclk) begin
            shreg <= shreg << 1;
            cnt <= cnt - CW'(1);
          end
        end
        default: gcnt <= gcnt + GW'(1);
      endcase
    end
  end
  assign act = state == SHIFT;
  assign o_busy = state != IDLE;
  assign o_vec_ack = (state == LOAD) & !sel;
  assign o_reg_ack = (state == LOAD) & sel;
  assign o_vec_csb = !(act & !sel);
  assign o_vec_sclk = act & !sel & sclk;
  assign o_vec_mosi = act & !sel & shreg[W-1];
  assign o_reg_csb = !(act & sel);
  assign o_reg_sclk = act & sel & sclk;
  assign o_reg_mosi = act & sel & shreg[W-1];
endmodule
